// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I execute stage: ALU operations, operand
// selects, branch funct3 codes and write-back result selects.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] SRCA_FWD  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;

  localparam logic [1:0] SRCB_FWD  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] WB_ALU = 3'd0;
  localparam logic [2:0] WB_MEM = 3'd1;
  localparam logic [2:0] WB_PC4 = 3'd2;
  localparam logic [2:0] WB_IMM = 3'd3;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU. Unused opcodes yield zero; shifts use SrcB[4:0].
module alu
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [3:0]      ALUOp,
  output logic [XLEN-1:0] Result
);

  logic signed [XLEN-1:0] sa;
  logic signed [XLEN-1:0] sb;
  logic        [4:0]      shamt;

  assign sa    = $signed(SrcA);
  assign sb    = $signed(SrcB);
  assign shamt = SrcB[4:0];

  // Operation decode; comparisons return a zero-extended single bit.
  always_comb begin
    Result = '0;
    case (ALUOp)
      ALU_ADD:   Result = SrcA + SrcB;
      ALU_SUB:   Result = SrcA - SrcB;
      ALU_SLL:   Result = SrcA << shamt;
      ALU_SLT:   Result = {{(XLEN-1){1'b0}}, (sa < sb)};
      ALU_SLTU:  Result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      ALU_XOR:   Result = SrcA ^ SrcB;
      ALU_SRL:   Result = SrcA >> shamt;
      ALU_SRA:   Result = sa >>> shamt;
      ALU_OR:    Result = SrcA | SrcB;
      ALU_AND:   Result = SrcA & SrcB;
      ALU_PASSB: Result = SrcB;
      default:   Result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational fetch redirect, and the EX/MEM pipeline register.
module ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallM,
  input  logic            FlushM,
  input  logic            RegWriteE,
  input  logic            MemReadE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            MuxjalrE,
  input  logic [3:0]      ALUOpE,
  input  logic [1:0]      ALUSrcAE,
  input  logic [1:0]      ALUSrcBE,
  input  logic [2:0]      WriteBackE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [4:0]      RdE,
  input  logic [4:0]      Rs1E,
  input  logic [4:0]      Rs2E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RdW,
  input  logic            RegWriteW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] ImmExtM,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemReadM,
  output logic            MemWriteM,
  output logic [2:0]      WriteBackM,
  output logic [2:0]      funct3M
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] pc_plus4;
  logic            br_cond;
  logic            mem_fwd_ok;
  logic            wb_fwd_ok;

  // A load result is not yet available in MEM, so MEM forwarding skips loads;
  // the hazard unit stalls those cases.
  assign mem_fwd_ok = RegWriteM && !MemReadM && (RdM != 5'd0);
  assign wb_fwd_ok  = RegWriteW && (RdW != 5'd0);

  // Operand A forwarding: MEM beats WB beats register file.
  always_comb begin
    fwd_a = RD1E;
    if (mem_fwd_ok && (RdM == Rs1E))     fwd_a = ALUResultM;
    else if (wb_fwd_ok && (RdW == Rs1E)) fwd_a = ResultW;
  end

  // Operand B forwarding, same priority as A.
  always_comb begin
    fwd_b = RD2E;
    if (mem_fwd_ok && (RdM == Rs2E))     fwd_b = ALUResultM;
    else if (wb_fwd_ok && (RdW == Rs2E)) fwd_b = ResultW;
  end

  // ALU input selection; unused codes select zero.
  always_comb begin
    src_a = '0;
    src_b = '0;
    case (ALUSrcAE)
      SRCA_FWD: src_a = fwd_a;
      SRCA_PC:  src_a = PCE;
      default:  src_a = '0;
    endcase
    case (ALUSrcBE)
      SRCB_FWD:  src_b = fwd_b;
      SRCB_IMM:  src_b = ImmExtE;
      SRCB_FOUR: src_b = FOUR;
      default:   src_b = '0;
    endcase
  end

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA   (src_a),
    .SrcB   (src_b),
    .ALUOp  (ALUOpE),
    .Result (alu_result)
  );

  // Branch condition on the forwarded operands; funct3 010/011 never take.
  always_comb begin
    br_cond = 1'b0;
    case (funct3E)
      BR_EQ:   br_cond = (fwd_a == fwd_b);
      BR_NE:   br_cond = (fwd_a != fwd_b);
      BR_LT:   br_cond = ($signed(fwd_a) <  $signed(fwd_b));
      BR_GE:   br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      BR_LTU:  br_cond = (fwd_a <  fwd_b);
      BR_GEU:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum  = fwd_a + ImmExtE;
  assign pc_plus4  = PCE + FOUR;
  assign PCSrcE    = JumpE | (BranchE & br_cond);
  assign PCTargetE = MuxjalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + ImmExtE);

  // EX/MEM register: reset and flush insert a bubble, stall holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      ImmExtM    <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      WriteBackM <= '0;
      funct3M    <= '0;
    end else if (FlushM) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      ImmExtM    <= '0;
      RdM        <= '0;
      RegWriteM  <= 1'b0;
      MemReadM   <= 1'b0;
      MemWriteM  <= 1'b0;
      WriteBackM <= '0;
      funct3M    <= '0;
    end else if (!StallM) begin
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= pc_plus4;
      ImmExtM    <= ImmExtE;
      RdM        <= RdE;
      RegWriteM  <= RegWriteE;
      MemReadM   <= MemReadE;
      MemWriteM  <= MemWriteE;
      WriteBackM <= WriteBackE;
      funct3M    <= funct3E;
    end
  end

endmodule
